// File: rtl/backup_mem_pkg.sv
// -----------------------------------------------------------------------------
// backup_mem_pkg
//   Shared types and default geometry for the line-granular backing store
//   (backup_memory_model) on the htif_clk domain.
//
//   Contents:
//     mem_state_e      control FSM state encoding (IDLE / WRITE / READ)
//     *_DEF            default parameter values for the top
//     BEAT_BITS        beat counter width for the default BEATS
//     beat_bits()      beat counter width for any BEATS (never below 1)
// -----------------------------------------------------------------------------
package backup_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } mem_state_e;

    localparam int ADDR_BITS_DEF   = 26;
    localparam int TAG_BITS_DEF    = 5;
    localparam int DATA_BITS_DEF   = 128;
    localparam int BEATS_DEF       = 4;
    localparam int DEPTH_LINES_DEF = 4096;

    localparam int BEAT_BITS = $clog2(BEATS_DEF);

    // A single-beat line still needs a 1-bit counter to keep the port legal.
    function automatic int beat_bits(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/backup_mem_array.sv
// -----------------------------------------------------------------------------
// backup_mem_array
//   Word-addressed storage for the backing store: one synchronous write port
//   and one asynchronous (combinational) read port. The array is named `ram`
//   so a simulation can preload it; it is never cleared.
//
//   Ports:
//     htif_clk  in   1          clock, write on rising edge
//     we        in   1          write enable
//     waddr     in   IDX_BITS   write word index
//     wdata     in   DATA_BITS  write data
//     raddr     in   IDX_BITS   read word index
//     rdata     out  DATA_BITS  read data (combinational)
// -----------------------------------------------------------------------------
module backup_mem_array #(
    parameter int DATA_BITS = 128,
    parameter int WORDS     = 16384,
    parameter int IDX_BITS  = 14
) (
    input  logic                 htif_clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic [IDX_BITS-1:0]  raddr,
    output logic [DATA_BITS-1:0] rdata
);

    logic [DATA_BITS-1:0] ram [WORDS];

    always_ff @(posedge htif_clk) begin
        if (we) begin
            ram[waddr] <= wdata;
        end
    end

    assign rdata = ram[raddr];

endmodule

// File: rtl/backup_memory_model.sv
// -----------------------------------------------------------------------------
// backup_memory_model
//   Line-granular backing store behind the narrow-to-wide deserialiser on the
//   slow host clock. One command per line: a write consumes BEATS data beats
//   (stalling indefinitely on data-valid gaps), a read streams BEATS response
//   beats on consecutive cycles with no backpressure. Commands are not queued.
//
//   Ports:
//     htif_clk            in   1          clock, rising edge
//     reset               in   1          synchronous, active-high
//     mem_req_valid       in   1          command valid
//     mem_req_ready       out  1          command accepted on valid&ready
//     mem_req_rw          in   1          1 = write, 0 = read
//     mem_req_addr        in   ADDR_BITS  line address (byte addr = {addr, 6'b0})
//     mem_req_tag         in   TAG_BITS   transaction tag
//     mem_req_data_valid  in   1          write beat valid
//     mem_req_data_ready  out  1          write beat accepted on valid&ready
//     mem_req_data_bits   in   DATA_BITS  write beat
//     mem_resp_valid      out  1          read beat valid
//     mem_resp_data       out  DATA_BITS  read beat
//     mem_resp_tag        out  TAG_BITS   tag of the read being returned
//
//   Build option:
//     BACKUP_MEM_BOUNDS_CHECK_EN  when defined, line addresses >= DEPTH_LINES
//                                 are out of range: write beats are handshaked
//                                 and dropped, reads return zeros, and one
//                                 $error is printed per command. When not
//                                 defined, the address wraps modulo DEPTH_LINES.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for a command; req_ready high, write beats ignored
//   WRITE | accepting BEATS write beats into the latched line
//   READ  | streaming BEATS response beats, one per cycle
// -----------------------------------------------------------------------------
module backup_memory_model
    import backup_mem_pkg::*;
#(
    parameter int ADDR_BITS   = ADDR_BITS_DEF,
    parameter int TAG_BITS    = TAG_BITS_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF,
    parameter int BEATS       = BEATS_DEF,
    parameter int DEPTH_LINES = DEPTH_LINES_DEF
) (
    input  logic                 htif_clk,
    input  logic                 reset,

    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    input  logic                 mem_req_rw,
    input  logic [ADDR_BITS-1:0] mem_req_addr,
    input  logic [TAG_BITS-1:0]  mem_req_tag,

    input  logic                 mem_req_data_valid,
    output logic                 mem_req_data_ready,
    input  logic [DATA_BITS-1:0] mem_req_data_bits,

    output logic                 mem_resp_valid,
    output logic [DATA_BITS-1:0] mem_resp_data,
    output logic [TAG_BITS-1:0]  mem_resp_tag
);

    localparam int BW       = beat_bits(BEATS);
    localparam int WORDS    = DEPTH_LINES * BEATS;
    localparam int IDX_BITS = $clog2(WORDS);

    mem_state_e           state;
    logic [ADDR_BITS-1:0] addr_q;
    logic [TAG_BITS-1:0]  tag_q;
    logic [BW-1:0]        beat_q;

    logic                 cmd_fire;
    logic                 data_fire;
    logic                 last_beat;
    logic [BW-1:0]        beat_next;
    logic                 in_range;
    logic [ADDR_BITS-1:0] line_mod;
    logic [IDX_BITS-1:0]  word_idx;
    logic                 ram_we;
    logic [DATA_BITS-1:0] ram_rdata;

    // Handshake outputs come straight from the state register; reset masks
    // them because the state only returns to IDLE on the first reset edge.
    assign mem_req_ready      = (state == IDLE)  && !reset;
    assign mem_req_data_ready = (state == WRITE) && !reset;
    assign mem_resp_valid     = (state == READ)  && !reset;

    assign cmd_fire  = mem_req_valid      && mem_req_ready;
    assign data_fire = mem_req_data_valid && mem_req_data_ready;

    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign beat_next = last_beat ? '0 : beat_q + BW'(1);

    // The low line-address bits select the physical line; with the bounds
    // check enabled the wrapped index is still formed but its effect masked.
    assign line_mod = addr_q % ADDR_BITS'(DEPTH_LINES);
    assign word_idx = IDX_BITS'(line_mod) * IDX_BITS'(BEATS) + IDX_BITS'(beat_q);

`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    assign in_range = (addr_q < ADDR_BITS'(DEPTH_LINES));
`else
    assign in_range = 1'b1;
`endif

    assign ram_we        = data_fire && in_range;
    assign mem_resp_data = in_range ? ram_rdata : '0;
    assign mem_resp_tag  = tag_q;

    // Control FSM.
    always_ff @(posedge htif_clk) begin
        if (reset) begin
            state  <= IDLE;
            beat_q <= '0;
            tag_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        addr_q <= mem_req_addr;
                        tag_q  <= mem_req_tag;
                        beat_q <= '0;
                        state  <= mem_req_rw ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (data_fire) begin
                        beat_q <= beat_next;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                READ: begin
                    beat_q <= beat_next;
                    if (last_beat) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    beat_q <= '0;
                end
            endcase
        end
    end

`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
    // One report per accepted command, at the acceptance edge.
    always_ff @(posedge htif_clk) begin
        if (!reset && cmd_fire && (mem_req_addr >= ADDR_BITS'(DEPTH_LINES))) begin
            $error("backup_memory_model: %s line 0x%0h out of range (depth %0d lines)",
                   mem_req_rw ? "write" : "read", mem_req_addr, DEPTH_LINES);
        end
    end
`endif

    backup_mem_array #(
        .DATA_BITS (DATA_BITS),
        .WORDS     (WORDS),
        .IDX_BITS  (IDX_BITS)
    ) u_array (
        .htif_clk (htif_clk),
        .we       (ram_we),
        .waddr    (word_idx),
        .wdata    (mem_req_data_bits),
        .raddr    (word_idx),
        .rdata    (ram_rdata)
    );

endmodule

// File: tb/tb_backup_memory_model.sv
// -----------------------------------------------------------------------------
// tb_backup_memory_model
//   Directed scenarios followed by a randomized run of line writes and reads.
//   Expected read data comes from a sparse model of the line store keyed by
//   (line mod depth, beat). Inputs change 1 time unit after the rising edge;
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_backup_memory_model;

    localparam int ADDR_BITS = 26;
    localparam int TAG_BITS  = 5;
    localparam int DATA_BITS = 128;
    localparam int BEATS     = 4;
    localparam int DEPTH     = 4096;

    logic                 htif_clk;
    logic                 reset;
    logic                 mem_req_valid;
    logic                 mem_req_ready;
    logic                 mem_req_rw;
    logic [ADDR_BITS-1:0] mem_req_addr;
    logic [TAG_BITS-1:0]  mem_req_tag;
    logic                 mem_req_data_valid;
    logic                 mem_req_data_ready;
    logic [DATA_BITS-1:0] mem_req_data_bits;
    logic                 mem_resp_valid;
    logic [DATA_BITS-1:0] mem_resp_data;
    logic [TAG_BITS-1:0]  mem_resp_tag;

    int n_assert = 0;
    int n_fail   = 0;

    // Sparse line store: key = physical_line*BEATS + beat.
    logic [DATA_BITS-1:0] mdl [int];

    backup_memory_model dut (
        .htif_clk           (htif_clk),
        .reset              (reset),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_req_rw         (mem_req_rw),
        .mem_req_addr       (mem_req_addr),
        .mem_req_tag        (mem_req_tag),
        .mem_req_data_valid (mem_req_data_valid),
        .mem_req_data_ready (mem_req_data_ready),
        .mem_req_data_bits  (mem_req_data_bits),
        .mem_resp_valid     (mem_resp_valid),
        .mem_resp_data      (mem_resp_data),
        .mem_resp_tag       (mem_resp_tag)
    );

    initial htif_clk = 1'b0;
    always #5 htif_clk = ~htif_clk;

    task automatic chk(input string tag, input logic [DATA_BITS-1:0] obs,
                       input logic [DATA_BITS-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_BITS-1:0] rand_data();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit line_in_range(input int line);
`ifdef BACKUP_MEM_BOUNDS_CHECK_EN
        return line < DEPTH;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int mkey(input int line, input int b);
        return (line % DEPTH) * BEATS + b;
    endfunction

    function automatic logic [DATA_BITS-1:0] model_read(input int line, input int b);
        if (!line_in_range(line)) return '0;
        return mdl[mkey(line, b)];
    endfunction

    function automatic bit line_known(input int line);
        if (!line_in_range(line)) return 1'b1;
        for (int b = 0; b < BEATS; b++)
            if (!mdl.exists(mkey(line, b))) return 1'b0;
        return 1'b1;
    endfunction

    // Entered and left 1 unit after a rising edge.
    task automatic issue(input bit rw, input int line, input int tag);
        bit acc = 1'b0;
        mem_req_valid = 1'b1;
        mem_req_rw    = rw;
        mem_req_addr  = ADDR_BITS'(line);
        mem_req_tag   = TAG_BITS'(tag);
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge htif_clk);
            if (mem_req_ready) acc = 1'b1;
            @(posedge htif_clk); #1;
        end
        mem_req_valid = 1'b0;
        chk("cmd_accepted", acc, 1);
    endtask

    task automatic write_beat(input int line, input int b, input logic [DATA_BITS-1:0] d);
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = d;
        @(negedge htif_clk);
        chk("wr_data_ready", mem_req_data_ready, 1);
        chk("wr_req_ready_busy", mem_req_ready, 0);
        @(posedge htif_clk); #1;
        mem_req_data_valid = 1'b0;
        if (line_in_range(line)) mdl[mkey(line, b)] = d;
    endtask

    task automatic wr_line(input int line, input int tag, input logic [DATA_BITS-1:0] d [BEATS],
                           input int gap_pos, input int gap_len);
        issue(1'b1, line, tag);
        for (int b = 0; b < BEATS; b++) begin
            if (b == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge htif_clk);
                    chk("gap_data_ready", mem_req_data_ready, 1);
                    chk("gap_req_ready", mem_req_ready, 0);
                    @(posedge htif_clk); #1;
                end
            end
            write_beat(line, b, d[b]);
        end
        @(negedge htif_clk);
        chk("wr_done_req_ready", mem_req_ready, 1);
        chk("wr_done_data_ready", mem_req_data_ready, 0);
        @(posedge htif_clk); #1;
    endtask

    task automatic check_burst(input int line, input int tag);
        for (int b = 0; b < BEATS; b++) begin
            @(negedge htif_clk);
            chk($sformatf("rd_valid_b%0d", b), mem_resp_valid, 1);
            chk($sformatf("rd_data_l%0h_b%0d", line, b), mem_resp_data, model_read(line, b));
            chk("rd_tag", mem_resp_tag, DATA_BITS'(tag));
            @(posedge htif_clk); #1;
        end
    endtask

    task automatic rd_line(input int line, input int tag);
        issue(1'b0, line, tag);
        check_burst(line, tag);
        @(negedge htif_clk);
        chk("rd_done_valid", mem_resp_valid, 0);
        chk("rd_done_req_ready", mem_req_ready, 1);
        @(posedge htif_clk); #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [DATA_BITS-1:0] d [BEATS];
        logic [DATA_BITS-1:0] nd [BEATS];

        reset              = 1'b1;
        mem_req_valid      = 1'b0;
        mem_req_rw         = 1'b0;
        mem_req_addr       = '0;
        mem_req_tag        = '0;
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = '0;

        // 1. reset held three cycles, all handshakes low
        for (int i = 0; i < 3; i++) begin
            @(negedge htif_clk);
            chk("rst_req_ready", mem_req_ready, 0);
            chk("rst_data_ready", mem_req_data_ready, 0);
            chk("rst_resp_valid", mem_resp_valid, 0);
        end
        @(posedge htif_clk); #1;
        reset = 1'b0;
        @(negedge htif_clk);
        chk("post_rst_req_ready", mem_req_ready, 1);
        chk("post_rst_resp_valid", mem_resp_valid, 0);
        @(posedge htif_clk); #1;

        // 2. write line 0x10, read it back with a different tag
        for (int b = 0; b < BEATS; b++) d[b] = DATA_BITS'(8'hA0 + b);
        wr_line(32'h10, 3, d, -1, 0);
        rd_line(32'h10, 7);

        // 3. two-cycle data-valid gap between beats 1 and 2
        for (int b = 0; b < BEATS; b++) d[b] = rand_data();
        wr_line(32'h21, 12, d, 2, 2);
        rd_line(32'h21, 4);

        // 4. line 2 loaded with 1..4, read while a second command is held
        for (int b = 0; b < BEATS; b++) d[b] = DATA_BITS'(b + 1);
        wr_line(2, 0, d, -1, 0);
        for (int b = 0; b < BEATS; b++) d[b] = rand_data();
        wr_line(3, 1, d, -1, 0);
        issue(1'b0, 2, 31);
        mem_req_valid = 1'b1;
        mem_req_rw    = 1'b0;
        mem_req_addr  = ADDR_BITS'(3);
        mem_req_tag   = TAG_BITS'(9);
        for (int b = 0; b < BEATS; b++) begin
            @(negedge htif_clk);
            chk("held_resp_valid", mem_resp_valid, 1);
            chk("held_resp_data", mem_resp_data, DATA_BITS'(b + 1));
            chk("held_resp_tag", mem_resp_tag, 31);
            chk("held_req_ready", mem_req_ready, 0);
            @(posedge htif_clk); #1;
        end
        @(negedge htif_clk);
        chk("held_accept_ready", mem_req_ready, 1);
        chk("held_gap_valid", mem_resp_valid, 0);
        @(posedge htif_clk); #1;
        mem_req_valid = 1'b0;
        check_burst(3, 9);
        @(negedge htif_clk);
        chk("held_done_valid", mem_resp_valid, 0);
        @(posedge htif_clk); #1;

        // 5. reset after write beat 1 of line 5
        for (int b = 0; b < BEATS; b++) d[b] = rand_data();
        wr_line(5, 2, d, -1, 0);
        for (int b = 0; b < BEATS; b++) nd[b] = rand_data();
        issue(1'b1, 5, 6);
        write_beat(5, 0, nd[0]);
        write_beat(5, 1, nd[1]);
        reset              = 1'b1;
        mem_req_data_valid = 1'b1;
        mem_req_data_bits  = nd[2];
        @(negedge htif_clk);
        chk("midrst_data_ready", mem_req_data_ready, 0);
        chk("midrst_req_ready", mem_req_ready, 0);
        @(posedge htif_clk); #1;
        reset              = 1'b0;
        mem_req_data_valid = 1'b0;
        @(negedge htif_clk);
        chk("midrst_idle_ready", mem_req_ready, 1);
        chk("midrst_idle_data_ready", mem_req_data_ready, 0);
        @(posedge htif_clk); #1;
        rd_line(5, 11);
        chk("midrst_line5_b2_old", mdl[mkey(5, 2)], d[2]);

        // 6. line beyond the physical depth
        for (int b = 0; b < BEATS; b++) d[b] = rand_data();
        wr_line(1, 8, d, -1, 0);
        rd_line(DEPTH + 1, 13);

        // randomized traffic
        for (int t = 0; t < 60; t++) begin
            int  line;
            bit  rw;
            line = int'($urandom_range(0, 7));
`ifndef BACKUP_MEM_BOUNDS_CHECK_EN
            if ($urandom_range(0, 3) == 0) line += DEPTH * int'($urandom_range(1, 3));
`endif
            rw = ($urandom_range(0, 1) == 1) || !line_known(line);
            if (rw) begin
                for (int b = 0; b < BEATS; b++) d[b] = rand_data();
                wr_line(line, int'($urandom_range(0, 31)), d,
                        int'($urandom_range(0, BEATS)), int'($urandom_range(0, 2)));
            end else begin
                rd_line(line, int'($urandom_range(0, 31)));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge htif_clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
